// File: rtl/bnn_output_layer.sv
// Binarised output layer: a serially loaded weight/threshold store and a
// sequential evaluator that scores one neuron per cycle with XNOR-popcount,
// reports per-neuron threshold hits and the index of the best-scoring neuron.
module bnn_output_layer #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int THR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup,
  input  logic              param_in,
  output logic              param_out,
  input  logic [N_IN-1:0]   hidden,
  input  logic              start,
  output logic              busy,
  output logic              class_valid,
  output logic [2:0]        class_out,
  output logic [N_OUT-1:0]  fire_mask
);

  localparam int FIELD_W = N_IN + THR_W;
  localparam int P_W     = N_OUT * FIELD_W;
  localparam int K_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SCORE_W = $clog2(N_IN + 1);
  localparam int CMP_W   = (SCORE_W > THR_W) ? SCORE_W : THR_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of agreeing bit positions between the hidden vector and a weight row.
  function automatic logic [CMP_W-1:0] match_count(
    input logic [N_IN-1:0] a,
    input logic [N_IN-1:0] b
  );
    logic [CMP_W-1:0] cnt;
    cnt = {CMP_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + {{(CMP_W-1){1'b0}}, ~(a[i] ^ b[i])};
    end
    return cnt;
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic [P_W-1:0]     p_r;
  logic [N_IN-1:0]    h_r;
  logic [K_W-1:0]     k_r;
  logic [K_W-1:0]     best_r;
  logic [CMP_W-1:0]   best_score_r;
  logic [N_OUT-1:0]   fire_work_r;

  logic [N_IN-1:0]    w_arr_s   [N_OUT];
  logic [THR_W-1:0]   thr_arr_s [N_OUT];
  logic [N_IN-1:0]    w_s;
  logic [CMP_W-1:0]   thr_s;
  logic [CMP_W-1:0]   score_s;
  logic               fire_s;
  logic               better_s;
  logic [N_OUT-1:0]   fire_nx_s;
  logic [K_W-1:0]     best_nx_s;
  logic [CMP_W-1:0]   best_score_nx_s;
  logic               eval_go_s;
  logic               start_go_s;

  // The chain tail is the top bit of the store, visible in every mode.
  assign param_out = p_r[P_W-1];

  // Split the flat store into per-neuron weight and threshold fields.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      w_arr_s[i]   = p_r[i*FIELD_W +: N_IN];
      thr_arr_s[i] = p_r[i*FIELD_W + N_IN +: THR_W];
    end
  end

  // Score the current neuron and fold it into the running mask and best index.
  always_comb begin
    w_s             = w_arr_s[k_r];
    thr_s           = CMP_W'(thr_arr_s[k_r]);
    score_s         = match_count(h_r, w_s);
    fire_s          = (score_s >= thr_s);
    better_s        = (score_s > best_score_r);
    fire_nx_s       = fire_work_r;
    fire_nx_s[k_r]  = fire_s;
    if (better_s) begin
      best_nx_s       = k_r;
      best_score_nx_s = score_s;
    end else begin
      best_nx_s       = best_r;
      best_score_nx_s = best_score_r;
    end
  end

  // Accept a request only from IDLE with no parameter load; setup aborts an evaluation.
  always_comb begin
    state_nx_s = state_r;
    start_go_s = 1'b0;
    eval_go_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !setup) begin
          state_nx_s = EVAL;
          start_go_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EVAL: begin
        if (setup) begin
          state_nx_s = IDLE;
        end else if (k_r == K_LAST) begin
          state_nx_s = DONE;
          eval_go_s  = 1'b1;
        end else begin
          state_nx_s = EVAL;
          eval_go_s  = 1'b1;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register with busy/class_valid registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      class_valid <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      busy        <= (state_nx_s == EVAL);
      class_valid <= (state_nx_s == DONE);
    end
  end

  // Parameter shift chain; it shifts whenever setup is high, whatever the FSM does.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_r <= {P_W{1'b0}};
    end else if (setup) begin
      p_r <= {p_r[P_W-2:0], param_in};
    end else begin
      p_r <= p_r;
    end
  end

  // Evaluation datapath; results are committed only on the final neuron so an
  // aborted run never disturbs the visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_r          <= {N_IN{1'b0}};
      k_r          <= {K_W{1'b0}};
      best_r       <= {K_W{1'b0}};
      best_score_r <= {CMP_W{1'b0}};
      fire_work_r  <= {N_OUT{1'b0}};
      class_out    <= 3'd0;
      fire_mask    <= {N_OUT{1'b0}};
    end else if (start_go_s) begin
      h_r          <= hidden;
      k_r          <= {K_W{1'b0}};
      best_r       <= {K_W{1'b0}};
      best_score_r <= {CMP_W{1'b0}};
      fire_work_r  <= {N_OUT{1'b0}};
    end else if (eval_go_s) begin
      k_r          <= k_r + {{(K_W-1){1'b0}}, 1'b1};
      best_r       <= best_nx_s;
      best_score_r <= best_score_nx_s;
      fire_work_r  <= fire_nx_s;
      if (k_r == K_LAST) begin
        class_out <= 3'(best_nx_s);
        fire_mask <= fire_nx_s;
      end else begin
        class_out <= class_out;
        fire_mask <= fire_mask;
      end
    end else begin
      h_r          <= h_r;
      k_r          <= k_r;
    end
  end

endmodule

// File: tb/tb_bnn_output_layer.sv
// Directed bench for bnn_output_layer: hand-computed classification results,
// parameter-chain timing, start filtering, setup abort and reset behaviour.
module tb_bnn_output_layer;

  logic        clk;
  logic        reset;
  logic        setup;
  logic        param_in;
  logic        param_out;
  logic [15:0] hidden;
  logic        start;
  logic        busy;
  logic        class_valid;
  logic [2:0]  class_out;
  logic [7:0]  fire_mask;

  int vectors;
  int miscompares;
  logic [167:0] pv;

  bnn_output_layer dut (
    .clk         (clk),
    .reset       (reset),
    .setup       (setup),
    .param_in    (param_in),
    .param_out   (param_out),
    .hidden      (hidden),
    .start       (start),
    .busy        (busy),
    .class_valid (class_valid),
    .class_out   (class_out),
    .fire_mask   (fire_mask)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [167:0] set_n(input logic [167:0] p, input int k,
                                         input logic [4:0] thr, input logic [15:0] w);
    logic [167:0] r;
    r = p;
    r[21*k +: 21] = {thr, w};
    return r;
  endfunction

  // Shift a full store image in MSB first; start is held on the first edge to
  // confirm it is ignored while loading.
  task automatic load_p(input logic [167:0] v);
    setup = 1'b1;
    start = 1'b1;
    for (int i = 167; i >= 0; i--) begin
      param_in = v[i];
      tick();
      if (i == 167) begin
        start = 1'b0;
        check_val("start_in_setup_busy", {31'd0, busy}, 32'd0);
      end
    end
    setup    = 1'b0;
    param_in = 1'b0;
  endtask

  // One full classification with latency and result checks.
  task automatic run_eval(input string tag, input logic [15:0] h,
                          input logic [2:0] exp_cls, input logic [7:0] exp_fire);
    hidden = h;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check_val({tag, "_early_valid"}, {31'd0, class_valid}, 32'd0);
      tick();
    end
    check_val({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, class_valid}, 32'd1);
    check_val({tag, "_class"}, {29'd0, class_out}, {29'd0, exp_cls});
    check_val({tag, "_fire"}, {24'd0, fire_mask}, {24'd0, exp_fire});
    tick();
    check_val({tag, "_valid_drop"}, {31'd0, class_valid}, 32'd0);
    check_val({tag, "_class_hold"}, {29'd0, class_out}, {29'd0, exp_cls});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    setup    = 1'b0;
    param_in = 1'b0;
    hidden   = 16'h0000;
    start    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check_val("rst_busy",  {31'd0, busy}, 32'd0);
    check_val("rst_valid", {31'd0, class_valid}, 32'd0);
    check_val("rst_class", {29'd0, class_out}, 32'd0);
    check_val("rst_fire",  {24'd0, fire_mask}, 32'd0);
    check_val("rst_pout",  {31'd0, param_out}, 32'd0);

    // Zero store, zero hidden: every score 16, every threshold 0.
    run_eval("zero", 16'h0000, 3'd0, 8'hFF);

    // Chain length: a single 1 reaches param_out on the 168th edge.
    setup = 1'b1;
    for (int i = 1; i <= 168; i++) begin
      param_in = (i == 1) ? 1'b1 : 1'b0;
      tick();
      check_val("chain_pout", {31'd0, param_out}, (i == 168) ? 32'd1 : 32'd0);
    end
    setup = 1'b0;
    tick();
    check_val("chain_hold", {31'd0, param_out}, 32'd1);

    // Neuron 3 is the only match.
    pv = 168'd0;
    for (int k = 0; k < 8; k++) pv = set_n(pv, k, 5'd1, 16'h0000);
    pv = set_n(pv, 3, 5'd16, 16'hFFFF);
    load_p(pv);
    run_eval("n3", 16'hFFFF, 3'd3, 8'b0000_1000);

    // Start during EVAL and DONE is ignored; a start in IDLE is taken.
    hidden = 16'hFFFF;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    tick();
    hidden = 16'h0000;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check_val("restart_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    check_val("restart_no_early", {31'd0, class_valid}, 32'd0);
    tick();
    check_val("restart_valid", {31'd0, class_valid}, 32'd1);
    check_val("restart_class", {29'd0, class_out}, 32'd3);
    hidden = 16'hFFFF;
    start  = 1'b1;
    tick();
    check_val("done_start_busy", {31'd0, busy}, 32'd0);
    check_val("done_start_valid", {31'd0, class_valid}, 32'd0);
    tick();
    start = 1'b0;
    check_val("idle_start_busy", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    check_val("idle_start_pending", {31'd0, class_valid}, 32'd0);
    tick();
    check_val("idle_start_valid", {31'd0, class_valid}, 32'd1);
    check_val("idle_start_fire", {24'd0, fire_mask}, 32'h08);
    tick();

    // Ties resolve to the lowest index; thresholds compared unsigned.
    pv = 168'd0;
    pv = set_n(pv, 0, 5'd0,  16'h5A5A);
    pv = set_n(pv, 1, 5'd1,  16'h5A5A);
    pv = set_n(pv, 2, 5'd1,  16'hA5A5);
    pv = set_n(pv, 3, 5'd1,  16'h5A5A);
    pv = set_n(pv, 4, 5'd1,  16'h5A5A);
    pv = set_n(pv, 5, 5'd17, 16'hA5A5);
    pv = set_n(pv, 6, 5'd1,  16'h5A5A);
    pv = set_n(pv, 7, 5'd16, 16'h5A5A);
    load_p(pv);
    run_eval("tie", 16'hA5A5, 3'd2, 8'h05);
    run_eval("near", 16'hA5A4, 3'd2, 8'h5F);

    // Setup during EVAL aborts and still shifts the chain.
    check_val("abort_pout_pre", {31'd0, param_out}, 32'd1);
    hidden = 16'h5A5A;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    setup    = 1'b1;
    param_in = 1'b0;
    tick();
    setup = 1'b0;
    check_val("abort_busy",  {31'd0, busy}, 32'd0);
    check_val("abort_valid", {31'd0, class_valid}, 32'd0);
    check_val("abort_class", {29'd0, class_out}, 32'd2);
    check_val("abort_fire",  {24'd0, fire_mask}, 32'h5F);
    check_val("abort_pout",  {31'd0, param_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("abort_no_valid", {31'd0, class_valid}, 32'd0);
    end
    check_val("abort_fire_keep", {24'd0, fire_mask}, 32'h5F);

    // Reset mid-EVAL beats setup and start.
    hidden = 16'hA5A4;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    reset    = 1'b1;
    setup    = 1'b1;
    start    = 1'b1;
    param_in = 1'b1;
    tick();
    reset    = 1'b0;
    setup    = 1'b0;
    start    = 1'b0;
    param_in = 1'b0;
    check_val("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check_val("mid_rst_valid", {31'd0, class_valid}, 32'd0);
    check_val("mid_rst_class", {29'd0, class_out}, 32'd0);
    check_val("mid_rst_fire",  {24'd0, fire_mask}, 32'd0);
    check_val("mid_rst_pout",  {31'd0, param_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("mid_rst_no_valid", {31'd0, class_valid}, 32'd0);
    end
    run_eval("post_rst", 16'h0000, 3'd0, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bnn_output_layer.md
BNN_OUTPUT_LAYER -- requirements
Module: bnn_output_layer

Interface
REQ-001 Parameter N_IN, default 16: width of the hidden-layer axon vector consumed.
REQ-002 Parameter N_OUT, default 8: number of output neurons, i.e. classes.
REQ-003 Parameter THR_W, default 5: threshold width per neuron.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 setup  input  1: parameter-load mode; shifts the parameter chain.
REQ-008 param_in  input  1: serial parameter bit, from the upstream chain tail.
REQ-009 param_out  output  1: serial parameter bit to the next chain stage.
REQ-010 hidden  input  N_IN: hidden-layer axon vector.
REQ-011 start  input  1: request one classification of the current hidden value.
REQ-012 busy  output  1: evaluation in progress.
REQ-013 class_valid  output  1: one-cycle result strobe.
REQ-014 class_out  output  3: winning class index.
REQ-015 fire_mask  output  N_OUT: per-neuron threshold-pass bits.

Function
REQ-016 Parameter store P SHALL be N_OUT*(N_IN+THR_W) bits, 168 bits by default.
REQ-017 Neuron k field SHALL be P[21k+20:21k]: bits [15:0] are weights w_k; bits [20:16] are threshold thr_k.
REQ-018 On each edge with setup=1, P SHALL load {P[166:0], param_in}.
REQ-019 param_out SHALL equal P[167] combinationally, in all modes.
REQ-020 With setup=0, P SHALL hold.
REQ-021 FSM states SHALL be IDLE, EVAL and DONE; busy=1 exactly in EVAL.
REQ-022 IDLE with start=1 and setup=0 at edge E SHALL latch hidden into h_reg, clear index k to 0, clear best_score, and enter EVAL.
REQ-023 In IDLE, start with setup=1 SHALL be ignored.
REQ-024 In EVAL and DONE, start SHALL be ignored; no queuing.
REQ-025 Each EVAL edge SHALL compute score_k = popcount(~(h_reg ^ w_k)), an unsigned value 0..16 held in 5 bits, for the current index k.
REQ-026 Each EVAL edge SHALL set fire_mask bit k to (score_k >= thr_k), using an unsigned compare.
REQ-027 Each EVAL edge SHALL set best to k when score_k > best_score; on ties the lowest index SHALL win.
REQ-028 Each EVAL edge SHALL then increment k.
REQ-029 Edges E+1..E+8 SHALL evaluate k=0..7; after edge E+8 the state SHALL be DONE.
REQ-030 In DONE, class_valid SHALL be 1 for exactly one cycle, with class_out = best index and fire_mask final.
REQ-031 The next edge SHALL return DONE to IDLE.
REQ-032 class_out and fire_mask SHALL hold their last values until the next DONE.
REQ-033 Latency SHALL be fixed: class_valid is high in the cycle following edge E+8.
REQ-034 Throughput SHALL be one result per 10 cycles.
REQ-035 setup=1 during EVAL or DONE SHALL abort: next state IDLE, class_valid=0, result registers unchanged; the parameter shift still occurs.
REQ-036 fire_mask and class_out SHALL only be updated in EVAL, so partial results are never visible with class_valid=1.

Reset
REQ-037 reset=1 at an edge SHALL set P=0, state=IDLE, k=0, h_reg=0, best_score=0, class_out=0, fire_mask=0, busy=0 and class_valid=0.
REQ-038 reset SHALL take priority over setup and start.
REQ-039 reset mid-EVAL SHALL discard the evaluation with no class_valid.
REQ-040 After reset, param_out SHALL be 0.

Verification
REQ-041 Reset, then start with hidden=16'h0000 -> busy high for 8 cycles; class_valid one cycle later than the start edge + 8; class_out=0; fire_mask=8'hFF (all scores 16, thresholds 0).
REQ-042 Load P with neuron 3 = {thr 5'd16, w 16'hFFFF} and all other neurons = {thr 5'd1, w 16'h0000}, then run hidden=16'hFFFF -> class_out=3, fire_mask=8'b0000_1000.
REQ-043 Shift 168 bits with the first bit 1 and the rest 0 -> param_out=1 exactly after edge 168, and 0 before.
REQ-044 Assert start again 3 cycles into EVAL -> ignored; exactly one class_valid pulse occurs and the next start is accepted only in IDLE.
REQ-045 Raise setup at EVAL cycle 4 -> busy=0 next cycle, no class_valid, class_out and fire_mask keep their previous values, and P has shifted by one.
REQ-046 Assert reset at EVAL cycle 5 -> all outputs 0 next cycle, param_out=0, and no class_valid.
